alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
Multi-cycle sequencer that runs unsigned multiply and divide (RV32M MUL, MULHU, DIVU, REMU) by driving one private ALU instance iteratively: ADD for shift-add multiply, SUB for restoring divide. It sits beside the main ALU in the execute stage. The stall logic uses busy/done to hold the core during the operation. All ALU work is done through the ALU's control encoding; no separate adder or subtractor exists outside it.

Parameters:
XLEN, 32, operand/result width (shared header value)
CNT_W, 6, iteration counter width (holds 0..XLEN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted when state != RUN
op  input  2  00 MUL (low word), 01 MULHU (high word), 10 DIVU (quotient), 11 REMU (remainder)
a  input  XLEN  multiplicand / dividend, sampled on accept
b  input  XLEN  multiplier / divisor, sampled on accept
busy  output  1  high while state == RUN
done  output  1  one-cycle pulse, result valid
result  output  XLEN  selected result; held until next accept or reset

Behaviour:
- Reset: one clock; synchronous and active-high (rst, sampled on the rising edge of clk). State is IDLE; busy=0, done=0, result=0, and all internal registers are 0. rst has priority over start in the same cycle.
- States:
  - IDLE: on start, capture op/a/b, clear the counter, go to RUN.
  - RUN: runs exactly XLEN cycles. After the iteration with counter == XLEN-1, go to DONE.
  - DONE: done=1 for this one cycle, and result is updated on the edge entering DONE. Next state is IDLE, or RUN if start=1 (back-to-back accept).
- Latency: start accepted at edge N, done high in cycle N+XLEN+1 (33 cycles for XLEN=32). The latency is fixed and does not depend on the data.
- start while busy=1 is ignored. Captured operands do not change mid-operation.
- Multiply (op[1]=0):
  - Registers: hi=0, lo=b, md=a.
  - Each RUN cycle: if lo[0], the ALU runs ADD on (hi, md) and carry = (alu_result < hi) unsigned; otherwise the sum is hi and carry=0.
  - Then {hi,lo} = {carry, sum, lo[XLEN-1:1]}.
  - At the end, MUL returns lo and MULHU returns hi.
- Divide (op[1]=1):
  - Registers: rem=0, quo=a, dv=b.
  - Each RUN cycle: sh = {rem[XLEN-2:0], quo[XLEN-1]}, and msb = rem[XLEN-1]. The ALU runs SUB on (sh, dv).
  - If msb or sh >= dv (unsigned): rem = alu_result and the new quotient bit is 1. Otherwise rem = sh and the bit is 0.
  - quo = {quo[XLEN-2:0], bit}.
  - At the end, DIVU returns quo and REMU returns rem.
- Divide by zero: no special path. The algorithm yields quo = all ones and rem = a, which matches RISC-V semantics.
- ALU control is driven only in RUN. The value in IDLE/DONE is don't-care, but it must be a defined constant (ADD) so there is no X-propagation.
- Reset mid-RUN aborts: there is no done pulse, and result returns to 0.
- Counter arithmetic is modulo 2^CNT_W. The counter never exceeds XLEN-1 in RUN.

Decomposition:
- Shared Parameters.vh supplies XLEN, ADD_OPCODE, SUB_OPCODE, plus the new op encodings MUL_OP, MULHU_OP, DIVU_OP, REMU_OP and the state encodings IDLE/RUN/DONE.
- One sub-module: the existing ALU, instantiated once as u_alu. The carry and compare logic stays in the sequencer.

Test Plan:
- MUL a=7, b=6 -> busy high for 32 cycles; done exactly 33 cycles after accept; result=0x0000002A.
- MULHU / MUL with a=b=0xFFFFFFFF -> MULHU result=0xFFFFFFFE, MUL result=0x00000001 (exercises the carry path).
- DIVU / REMU with a=100, b=7 -> quotient 14 and remainder 2; a=0x80000000, b=3 -> quotient 0x2AAAAAAA and remainder 2.
- Divide by zero, a=0x00001234, b=0 -> DIVU 0xFFFFFFFF, REMU 0x00001234.
- Control events:
  - start pulsed with new operands at cycle 10 of RUN -> ignored; the original result is returned.
  - start in the DONE cycle -> the next op is accepted with no IDLE gap.
- Reset checks:
  - rst asserted at cycle 10 of RUN -> next cycle busy=0 and result=0; no done pulse occurs.
  - rst and start asserted together -> stays IDLE.

Source files
------------

// File: rtl/alu_muldiv_seq_pkg.sv
// Shared widths, ALU control encoding, mul/div op encoding and sequencer states.
package alu_muldiv_seq_pkg;

  localparam int unsigned Xlen = 32;
  localparam int unsigned CntW = 6;

  // Control encoding understood by the execute-stage ALU.
  typedef enum logic [2:0] {
    AluAdd  = 3'd0,
    AluSub  = 3'd1,
    AluAnd  = 3'd2,
    AluOr   = 3'd3,
    AluXor  = 3'd4,
    AluSltu = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    OpMul   = 2'b00,
    OpMulhu = 2'b01,
    OpDivu  = 2'b10,
    OpRemu  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// Execute-stage ALU; the mul/div sequencer owns a private instance of it.
module alu_muldiv_seq_alu import alu_muldiv_seq_pkg::*; #(
  parameter int unsigned XLEN = Xlen
) (
  input  logic [2:0]      i_ctrl,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  // Combinational operation select; unknown codes fall back to ADD.
  always_comb begin
    o_result = i_a + i_b;
    case (alu_op_e'(i_ctrl))
      AluAdd:  o_result = i_a + i_b;
      AluSub:  o_result = i_a - i_b;
      AluAnd:  o_result = i_a & i_b;
      AluOr:   o_result = i_a | i_b;
      AluXor:  o_result = i_a ^ i_b;
      AluSltu: o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      default: o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Fixed-latency unsigned MUL/MULHU/DIVU/REMU sequencer built around one ALU.
// Multiply: shift-add with {hi,lo}; divide: restoring with {rem,quo}.
// r_hi doubles as hi/rem, r_lo as lo/quo and r_md as multiplicand/divisor.
module alu_muldiv_seq import alu_muldiv_seq_pkg::*; #(
  parameter int unsigned XLEN  = Xlen,
  parameter int unsigned CNT_W = CntW
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  md_state_e         r_state, w_state_d;
  logic [1:0]        r_op, w_op_d;
  logic [XLEN-1:0]   r_hi, w_hi_d;
  logic [XLEN-1:0]   r_lo, w_lo_d;
  logic [XLEN-1:0]   r_md, w_md_d;
  logic [CNT_W-1:0]  r_cnt, w_cnt_d;
  logic [XLEN-1:0]   r_result, w_result_d;

  logic              w_div;
  logic [XLEN-1:0]   w_sh;
  logic [XLEN-1:0]   w_alu_a;
  logic [2:0]        w_alu_ctrl;
  logic [XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]   w_sum;
  logic              w_carry;
  logic              w_take;
  logic [XLEN-1:0]   w_step_hi, w_step_lo;

  assign w_div   = r_op[1];
  assign w_sh    = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
  assign w_alu_a = w_div ? w_sh : r_hi;

  // ALU control: SUB only while dividing in RUN, otherwise a fixed ADD.
  always_comb begin
    w_alu_ctrl = 3'(AluAdd);
    if (r_state == StRun && w_div) begin
      w_alu_ctrl = 3'(AluSub);
    end
  end

  alu_muldiv_seq_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .i_ctrl   (w_alu_ctrl),
    .i_a      (w_alu_a),
    .i_b      (r_md),
    .o_result (w_alu_res)
  );

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    w_sum     = r_lo[0] ? w_alu_res : r_hi;
    w_carry   = r_lo[0] && (w_alu_res < r_hi);
    // rem[XLEN-1] set means the shifted value overflowed XLEN bits, so it exceeds dv.
    w_take    = r_hi[XLEN-1] || (w_sh >= r_md);
    w_step_hi = {w_carry, w_sum[XLEN-1:1]};
    w_step_lo = {w_sum[0], r_lo[XLEN-1:1]};
    if (w_div) begin
      w_step_hi = w_take ? w_alu_res : w_sh;
      w_step_lo = {r_lo[XLEN-2:0], w_take};
    end
  end

  // Next-state logic: accept in IDLE/DONE, iterate XLEN times in RUN.
  always_comb begin
    w_state_d  = r_state;
    w_op_d     = r_op;
    w_hi_d     = r_hi;
    w_lo_d     = r_lo;
    w_md_d     = r_md;
    w_cnt_d    = r_cnt;
    w_result_d = r_result;
    case (r_state)
      StRun: begin
        w_hi_d  = w_step_hi;
        w_lo_d  = w_step_lo;
        w_cnt_d = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_state_d = StDone;
          w_cnt_d   = '0;
          unique case (md_op_e'(r_op))
            OpMul:   w_result_d = w_step_lo;
            OpMulhu: w_result_d = w_step_hi;
            OpDivu:  w_result_d = w_step_lo;
            OpRemu:  w_result_d = w_step_hi;
          endcase
        end
      end
      StIdle, StDone: begin
        w_state_d = StIdle;
        if (i_start) begin
          w_state_d = StRun;
          w_op_d    = i_op;
          w_hi_d    = '0;
          w_lo_d    = i_op[1] ? i_a : i_b;
          w_md_d    = i_op[1] ? i_b : i_a;
          w_cnt_d   = '0;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_md     <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_d;
      r_op     <= w_op_d;
      r_hi     <= w_hi_d;
      r_lo     <= w_lo_d;
      r_md     <= w_md_d;
      r_cnt    <= w_cnt_d;
      r_result <= w_result_d;
    end
  end

  assign o_busy   = (r_state == StRun);
  assign o_done   = (r_state == StDone);
  assign o_result = r_result;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: driver pushes expected results, monitor pops on done.
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu_muldiv_seq u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start),
    .i_op     (op),
    .i_a      (a),
    .i_b      (b),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RV32M unsigned semantics from plain wide arithmetic.
  function automatic logic [31:0] model(input logic [1:0] m_op, input logic [31:0] m_a,
                                        input logic [31:0] m_b);
    logic [63:0] prod;
    prod = {32'd0, m_a} * {32'd0, m_b};
    case (m_op)
      2'b00:   return prod[31:0];
      2'b01:   return prod[63:32];
      2'b10:   return (m_b == 0) ? 32'hFFFF_FFFF : m_a / m_b;
      default: return (m_b == 0) ? m_a : m_a % m_b;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // Drive a request (caller is at a negedge) and log its expected result.
  task automatic issue(input logic [1:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                       input logic [31:0] exp);
    start = 1'b1;
    op    = i_op;
    a     = i_a;
    b     = i_b;
    exp_q.push_back(exp);
  endtask

  // Wait for done; cycle 1 is the first negedge after the accepting edge.
  task automatic wait_done(input int start_cycle);
    int cyc;
    int busy_cnt;
    cyc      = start_cycle;
    busy_cnt = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'd33);
    check("busy_cycles", 32'(busy_cnt), 32'(33 - start_cycle));
  endtask

  task automatic do_op(input logic [1:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                       input logic [31:0] exp);
    @(negedge clk);
    issue(i_op, i_a, i_b, exp);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(1);
  endtask

  task automatic count_dones(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done === 1'b1) cnt++;
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done got result %h expected no done", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int ndone;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    // Directed arithmetic cases.
    do_op(2'b00, 32'd7, 32'd6, 32'h0000_002A);
    repeat (3) @(negedge clk);
    check("result_held", result, 32'h0000_002A);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_op(2'b10, 32'd100, 32'd7, 32'd14);
    do_op(2'b11, 32'd100, 32'd7, 32'd2);
    do_op(2'b10, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA);
    do_op(2'b11, 32'h8000_0000, 32'd3, 32'd2);
    do_op(2'b10, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
    do_op(2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234);

    // start during RUN is ignored; original operands finish.
    @(negedge clk);
    issue(2'b00, 32'd7, 32'd6, 32'h0000_002A);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1;
    op    = 2'b10;
    a     = 32'd999;
    b     = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(11);
    @(negedge clk);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Back-to-back accept in the DONE cycle.
    do_op(2'b00, 32'd5, 32'd3, 32'd15);
    issue(2'b10, 32'd100, 32'd7, 32'd14);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(1);

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", result, 32'd0);
    count_dones(40, ndone);
    check("abort_no_done", 32'(ndone), 32'd0);

    // rst and start together: stays IDLE.
    start = 1'b1;
    rst   = 1'b1;
    op    = 2'b00;
    a     = 32'd3;
    b     = 32'd4;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    count_dones(40, ndone);
    check("rst_start_no_done", 32'(ndone), 32'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      do_op(r_op, r_a, r_b, model(r_op, r_a, r_b));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
